uart_tx_arbiter: RTL and testbench

Shares the single 40-bit TX frame port of the UART controller between three frame producers: ADS1292 sample frames, MPR121 sample frames and register-read replies. Each producer gets a one-entry frame buffer with a valid/ready handshake. The arbiter grants one buffered frame at a time and drives the controller's TX valid/ready handshake until the frame is accepted and transmitted. It also drops frames with an unknown header and watches for a stalled controller.

---
 rtl/uart_tx_arbiter_if.sv | 39 +++
 rtl/uart_tx_arbiter.sv | 172 +++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if
//   Bundles the three producer handshakes, the UART controller TX handshake and
//   the arbiter status outputs into one port.
//   slave  : arbiter side (consumes producer frames, drives the controller).
//   master : producer/controller side (testbench or surrounding logic).
//   Signals:
//     i_{ADS,MPR,REG}_DATA[39:0], i_{ADS,MPR,REG}_VALID, o_{ADS,MPR,REG}_READY
//     o_UART_DATA_TX[39:0], o_UART_DATA_TX_VALID, i_UART_DATA_TX_READY
//     o_DROP_CNT[7:0], o_TIMEOUT
interface uart_tx_arbiter_if;
  logic [39:0] i_ADS_DATA;
  logic        i_ADS_VALID;
  logic        o_ADS_READY;
  logic [39:0] i_MPR_DATA;
  logic        i_MPR_VALID;
  logic        o_MPR_READY;
  logic [39:0] i_REG_DATA;
  logic        i_REG_VALID;
  logic        o_REG_READY;
  logic [39:0] o_UART_DATA_TX;
  logic        o_UART_DATA_TX_VALID;
  logic        i_UART_DATA_TX_READY;
  logic [7:0]  o_DROP_CNT;
  logic        o_TIMEOUT;

  modport slave (
    input  i_ADS_DATA, i_ADS_VALID, i_MPR_DATA, i_MPR_VALID,
           i_REG_DATA, i_REG_VALID, i_UART_DATA_TX_READY,
    output o_ADS_READY, o_MPR_READY, o_REG_READY,
           o_UART_DATA_TX, o_UART_DATA_TX_VALID, o_DROP_CNT, o_TIMEOUT
  );

  modport master (
    output i_ADS_DATA, i_ADS_VALID, i_MPR_DATA, i_MPR_VALID,
           i_REG_DATA, i_REG_VALID, i_UART_DATA_TX_READY,
    input  o_ADS_READY, o_MPR_READY, o_REG_READY,
           o_UART_DATA_TX, o_UART_DATA_TX_VALID, o_DROP_CNT, o_TIMEOUT
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares the 40-bit UART TX frame port between the ADS sample, MPR sample and
//   register-reply producers. Each producer owns a one-entry buffer; the FSM
//   grants one buffered frame at a time, holds it on the controller handshake
//   until READY falls (accepted) and then waits for READY to return (sent).
//   Frames with an unknown header are dropped and counted; a frame the
//   controller never accepts is aborted after ACK_TIMEOUT cycles.
// Ports:
//   i_CLK  clock
//   i_RST  asynchronous active-high reset
//   bus    uart_tx_arbiter_if.slave (producer handshakes, controller TX
//          handshake, o_DROP_CNT, o_TIMEOUT)
// Build option:
//   UART_ARB_ROUND_ROBIN_EN  defined   : round-robin ADS -> MPR -> REG
//                            undefined : fixed priority REG > ADS > MPR
module uart_tx_arbiter #(
  parameter logic [15:0] ACK_TIMEOUT = 16'd50000,
  parameter logic [7:0]  HDR_ADS     = 8'h41,
  parameter logic [7:0]  HDR_MPR     = 8'h4D,
  parameter logic [7:0]  HDR_ADS_REG = 8'h61,
  parameter logic [7:0]  HDR_MPR_REG = 8'h6D
) (
  input logic             i_CLK,
  input logic             i_RST,
  uart_tx_arbiter_if.slave bus
);
  localparam int         NUM_SRC = 3;
  localparam logic [1:0] SRC_ADS = 2'd0;
  localparam logic [1:0] SRC_MPR = 2'd1;
  localparam logic [1:0] SRC_REG = 2'd2;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_BUSY} state_t;

  state_t                         state, state_nxt;
  logic [NUM_SRC-1:0]             src_vld, buf_full, buf_clr;
  logic [NUM_SRC-1:0][39:0]       src_data, buf_data;
  logic                           win_vld, grant, drop, tmo_hit;
  logic [1:0]                     win_idx;
  logic [15:0]                    tmo_cnt;
  logic [39:0]                    tx_data;
  logic [7:0]                     drop_cnt;
  logic                           tmo_pulse;

  function automatic logic hdr_ok(input logic [7:0] h);
    return (h == HDR_ADS) || (h == HDR_MPR) || (h == HDR_ADS_REG) || (h == HDR_MPR_REG);
  endfunction

  assign src_vld  = {bus.i_REG_VALID, bus.i_MPR_VALID, bus.i_ADS_VALID};
  assign src_data = {bus.i_REG_DATA,  bus.i_MPR_DATA,  bus.i_ADS_DATA};

  assign bus.o_ADS_READY          = ~buf_full[SRC_ADS];
  assign bus.o_MPR_READY          = ~buf_full[SRC_MPR];
  assign bus.o_REG_READY          = ~buf_full[SRC_REG];
  assign bus.o_UART_DATA_TX       = tx_data;
  assign bus.o_UART_DATA_TX_VALID = (state == ST_REQ);
  assign bus.o_DROP_CNT           = drop_cnt;
  assign bus.o_TIMEOUT            = tmo_pulse;

  // One-entry buffers. A buffer is never captured into and cleared in the
  // same cycle: clearing needs it full, capture needs it empty.
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      buf_full <= '0;
      buf_data <= '0;
    end else begin
      for (int s = 0; s < NUM_SRC; s++) begin
        if (buf_clr[s]) begin
          buf_full[s] <= 1'b0;
        end else if (src_vld[s] && !buf_full[s]) begin
          buf_full[s] <= 1'b1;
          buf_data[s] <= src_data[s];
        end
      end
    end
  end

  // Winner select. A bad-header frame still wins its slot; the FSM then
  // drops it instead of granting it.
`ifdef UART_ARB_ROUND_ROBIN_EN
  logic [1:0] rr_ptr;

  function automatic logic [1:0] rr_at(input logic [1:0] p, input int k);
    int j;
    j = int'(p) + k;
    if (j >= NUM_SRC) j = j - NUM_SRC;
    return 2'(j);
  endfunction

  always_comb begin
    win_vld = 1'b0;
    win_idx = SRC_ADS;
    // Walk from farthest to nearest so the source closest to the pointer wins.
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (buf_full[rr_at(rr_ptr, k)]) begin
        win_vld = 1'b1;
        win_idx = rr_at(rr_ptr, k);
      end
    end
  end

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST)
      rr_ptr <= SRC_ADS;
    else if (grant || drop)
      rr_ptr <= (win_idx == SRC_REG) ? SRC_ADS : win_idx + 2'd1;
  end
`else
  always_comb begin
    win_vld = 1'b1;
    win_idx = SRC_ADS;
    if (buf_full[SRC_REG])      win_idx = SRC_REG;
    else if (buf_full[SRC_ADS]) win_idx = SRC_ADS;
    else if (buf_full[SRC_MPR]) win_idx = SRC_MPR;
    else                        win_vld = 1'b0;
  end
`endif

  always_comb begin
    state_nxt = state;
    buf_clr   = '0;
    grant     = 1'b0;
    drop      = 1'b0;
    tmo_hit   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (win_vld && bus.i_UART_DATA_TX_READY) begin
          buf_clr[win_idx] = 1'b1;
          if (hdr_ok(buf_data[win_idx][39:32])) begin
            grant     = 1'b1;
            state_nxt = ST_REQ;
          end else begin
            drop = 1'b1;
          end
        end
      end
      ST_REQ: begin
        // READY falling is the only acceptance indication; it beats a
        // timeout landing on the same cycle.
        if (!bus.i_UART_DATA_TX_READY) begin
          state_nxt = ST_BUSY;
        end else if (tmo_cnt == ACK_TIMEOUT - 16'd1) begin
          tmo_hit   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (bus.i_UART_DATA_TX_READY) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state     <= ST_IDLE;
      tmo_cnt   <= '0;
      tx_data   <= '0;
      drop_cnt  <= '0;
      tmo_pulse <= 1'b0;
    end else begin
      state     <= state_nxt;
      tmo_pulse <= tmo_hit;
      if (grant) begin
        tx_data <= buf_data[win_idx];
        tmo_cnt <= '0;
      end else if (state == ST_REQ) begin
        tmo_cnt <= tmo_cnt + 16'd1;
      end
      if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
//   Directed scenarios (latency, arbitration order, header drops and
//   saturation, ack timeout, controller ignoring VALID, reset mid-frame)
//   followed by a randomized phase checked against a frame scoreboard.
module tb_uart_tx_arbiter;
  localparam logic [15:0] TMO = 16'd16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_arbiter_if bus();
  uart_tx_arbiter #(.ACK_TIMEOUT(TMO)) dut (.i_CLK(clk), .i_RST(rst), .bus(bus));

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference header rule
  function automatic bit good_hdr(input logic [7:0] h);
    return h == 8'h41 || h == 8'h4D || h == 8'h61 || h == 8'h6D;
  endfunction

  // ---------------- controller model ----------------
  bit          ctl_accept = 1'b1;
  bit          ctl_rand   = 1'b0;
  int          ctl_delay  = 0;
  int          ctl_busy   = 2;
  int          n_acc      = 0;
  logic [39:0] acc_q[$];

  initial begin
    bus.i_UART_DATA_TX_READY = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst && bus.o_UART_DATA_TX_VALID && ctl_accept) begin
        logic [39:0] fr;
        int d, b;
        fr = bus.o_UART_DATA_TX;
        d  = ctl_rand ? int'($urandom_range(0, 5)) : ctl_delay;
        b  = ctl_rand ? int'($urandom_range(1, 6)) : ctl_busy;
        for (int i = 0; i < d; i++) begin
          @(negedge clk);
          chk("hold_valid", bus.o_UART_DATA_TX_VALID, 1);
          chk("hold_data", bus.o_UART_DATA_TX, fr);
        end
        bus.i_UART_DATA_TX_READY = 1'b0;
        acc_q.push_back(fr);
        n_acc++;
        @(negedge clk);
        chk("valid_drop", bus.o_UART_DATA_TX_VALID, 0);
        for (int i = 1; i < b; i++) @(negedge clk);
        bus.i_UART_DATA_TX_READY = 1'b1;
      end
    end
  end

  // ---------------- producer helpers ----------------
  task automatic drive(input int s, input logic v, input logic [39:0] d);
    case (s)
      0:       begin bus.i_ADS_VALID = v; bus.i_ADS_DATA = d; end
      1:       begin bus.i_MPR_VALID = v; bus.i_MPR_DATA = d; end
      default: begin bus.i_REG_VALID = v; bus.i_REG_DATA = d; end
    endcase
  endtask

  function automatic logic src_rdy(input int s);
    case (s)
      0:       return bus.o_ADS_READY;
      1:       return bus.o_MPR_READY;
      default: return bus.o_REG_READY;
    endcase
  endfunction

  task automatic send(input int s, input logic [39:0] d);
    drive(s, 1'b1, d);
    @(negedge clk);
    drive(s, 1'b0, '0);
  endtask

  task automatic wait_acc(input int n, input int lim);
    int t = 0;
    while (n_acc < n && t < lim) begin @(negedge clk); t++; end
    chk("acc_count", n_acc, n);
  endtask

  task automatic wait_idle();
    int t = 0;
    while (!(bus.i_UART_DATA_TX_READY && !bus.o_UART_DATA_TX_VALID) && t < 200) begin
      @(negedge clk); t++;
    end
    chk("idle_reached", t < 200, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int s = 0; s < 3; s++) drive(s, 1'b0, '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_acc = 0;
    acc_q.delete();
  endtask

  function automatic logic [39:0] rand_frame(input int s);
    logic [7:0]  h;
    logic [31:0] r;
    r = $urandom();
    case ($urandom_range(0, 7))
      0:       h = 8'h58;
      1, 2:    h = 8'h41;
      3, 4:    h = 8'h4D;
      5:       h = 8'h61;
      default: h = 8'h6D;
    endcase
    return {h, r[31:2], 2'(s)};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [39:0] exp_all[$];
    bit          sv[3];
    logic        sr[3];
    logic [39:0] sd[3];
    int          exp_drop, tmo_seen, t, vcnt;

    for (int s = 0; s < 3; s++) drive(s, 1'b0, '0);
    do_reset();

    // Reset state
    chk("rst_ads_ready", bus.o_ADS_READY, 1);
    chk("rst_mpr_ready", bus.o_MPR_READY, 1);
    chk("rst_reg_ready", bus.o_REG_READY, 1);
    chk("rst_valid", bus.o_UART_DATA_TX_VALID, 0);
    chk("rst_data", bus.o_UART_DATA_TX, 0);
    chk("rst_drop", bus.o_DROP_CNT, 0);
    chk("rst_timeout", bus.o_TIMEOUT, 0);

    // Latency: valid presented in cycle N -> buffer full in N+1 -> VALID in N+2
    ctl_delay = 3; ctl_busy = 4;
    drive(0, 1'b1, 40'h4111223344);
    @(negedge clk);
    chk("lat_ads_full", bus.o_ADS_READY, 0);
    chk("lat_valid_early", bus.o_UART_DATA_TX_VALID, 0);
    drive(0, 1'b0, '0);
    @(negedge clk);
    chk("lat_valid", bus.o_UART_DATA_TX_VALID, 1);
    chk("lat_data", bus.o_UART_DATA_TX, 40'h4111223344);
    chk("lat_ads_ready", bus.o_ADS_READY, 1);
    wait_acc(1, 50);
    chk("lat_frame", acc_q.size() > 0 ? acc_q[0] : 40'h0, 40'h4111223344);
    wait_idle();

    // Arbitration order with REG and ADS offered together
    do_reset();
    ctl_delay = 0; ctl_busy = 3;
    drive(0, 1'b1, 40'h41AAAAAAA0);
    drive(2, 1'b1, 40'h61BBBBBBB2);
    @(negedge clk);
    drive(0, 1'b0, '0);
    drive(2, 1'b0, '0);
    wait_acc(2, 100);
`ifdef UART_ARB_ROUND_ROBIN_EN
    chk("arb_first", acc_q.size() > 1 ? acc_q[0] : 40'h0, 40'h41AAAAAAA0);
    chk("arb_second", acc_q.size() > 1 ? acc_q[1] : 40'h0, 40'h61BBBBBBB2);
`else
    chk("arb_first", acc_q.size() > 1 ? acc_q[0] : 40'h0, 40'h61BBBBBBB2);
    chk("arb_second", acc_q.size() > 1 ? acc_q[1] : 40'h0, 40'h41AAAAAAA0);
`endif
    wait_idle();

    // Bad header drop and saturation
    do_reset();
    chk("drop_init", bus.o_DROP_CNT, 0);
    send(1, 40'h5800000000);
    chk("drop_mpr_full", bus.o_MPR_READY, 0);
    @(negedge clk);
    chk("drop_mpr_ready", bus.o_MPR_READY, 1);
    chk("drop_cnt_1", bus.o_DROP_CNT, 1);
    chk("drop_no_valid", bus.o_UART_DATA_TX_VALID, 0);
    for (int i = 1; i < 300; i++) begin
      send(1, {8'h58, 32'($urandom())});
      @(negedge clk);
    end
    chk("drop_sat", bus.o_DROP_CNT, 255);
    chk("drop_no_frames", n_acc, 0);

    // Ack timeout: controller never lowers READY
    do_reset();
    ctl_accept = 1'b0;
    send(0, 40'h4100000010);
    send(1, 40'h4D00000021);
    t = 0;
    while (!bus.o_UART_DATA_TX_VALID && t < 20) begin @(negedge clk); t++; end
    vcnt = 0;
    while (bus.o_UART_DATA_TX_VALID && vcnt < 100) begin vcnt++; @(negedge clk); end
    chk("tmo_valid_len", vcnt, 16);
    chk("tmo_pulse", bus.o_TIMEOUT, 1);
    ctl_accept = 1'b1;
    @(negedge clk);
    chk("tmo_pulse_end", bus.o_TIMEOUT, 0);
    wait_acc(1, 50);
    chk("tmo_next_frame", acc_q.size() > 0 ? acc_q[0] : 40'h0, 40'h4D00000021);
    wait_idle();

    // Controller ignores VALID for 5 cycles
    do_reset();
    ctl_delay = 5; ctl_busy = 3;
    send(2, 40'h6D12345678);
    wait_acc(1, 50);
    repeat (20) @(negedge clk);
    chk("ign_one_frame", n_acc, 1);
    chk("ign_frame", acc_q.size() > 0 ? acc_q[0] : 40'h0, 40'h6D12345678);
    wait_idle();

    // Reset while the controller is busy with buffers full
    do_reset();
    ctl_delay = 0; ctl_busy = 30;
    send(1, 40'h0700000000);
    @(negedge clk);
    send(2, 40'h6100000042);
    wait_acc(1, 50);
    @(negedge clk);
    drive(0, 1'b1, 40'h4100000050);
    drive(1, 1'b1, 40'h4D00000051);
    @(negedge clk);
    drive(0, 1'b0, '0);
    drive(1, 1'b0, '0);
    chk("mid_ads_full", bus.o_ADS_READY, 0);
    chk("mid_mpr_full", bus.o_MPR_READY, 0);
    chk("mid_drop_pre", bus.o_DROP_CNT, 1);
    rst = 1'b1;
    #1;
    chk("mid_ads_ready", bus.o_ADS_READY, 1);
    chk("mid_mpr_ready", bus.o_MPR_READY, 1);
    chk("mid_reg_ready", bus.o_REG_READY, 1);
    chk("mid_valid", bus.o_UART_DATA_TX_VALID, 0);
    chk("mid_drop", bus.o_DROP_CNT, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send(0, 40'h4100000077);
    wait_acc(2, 100);
    chk("mid_after_frame", acc_q.size() > 1 ? acc_q[1] : 40'h0, 40'h4100000077);
    repeat (20) @(negedge clk);
    chk("mid_no_stale", n_acc, 2);
    ctl_busy = 2;
    wait_idle();

    // Randomized traffic against the scoreboard
    do_reset();
    ctl_rand = 1'b1;
    exp_drop = 0;
    tmo_seen = 0;
    for (int s = 0; s < 3; s++) begin sv[s] = 1'b0; sr[s] = 1'b0; sd[s] = '0; end
    for (int cyc = 0; cyc < 2600; cyc++) begin
      @(negedge clk);
      if (bus.o_TIMEOUT) tmo_seen++;
      for (int s = 0; s < 3; s++) begin
        if (sv[s] && sr[s]) begin
          if (good_hdr(sd[s][39:32])) exp_all.push_back(sd[s]);
          else exp_drop++;
          sv[s] = 1'b0;
        end
      end
      while (acc_q.size() > 0) begin
        logic [39:0] fr;
        int found;
        fr = acc_q.pop_front();
        found = -1;
        foreach (exp_all[i]) if (found < 0 && exp_all[i][1:0] == fr[1:0]) found = i;
        chk("sb_match", found >= 0, 1);
        if (found >= 0) begin
          chk("sb_frame", fr, exp_all[found]);
          exp_all.delete(found);
        end
      end
      for (int s = 0; s < 3; s++) begin
        if (cyc < 2000 && !sv[s] && $urandom_range(0, 3) == 0) begin
          sv[s] = 1'b1;
          sd[s] = rand_frame(s);
        end
        sr[s] = src_rdy(s);
        drive(s, sv[s], sv[s] ? sd[s] : 40'h0);
      end
    end
    chk("rnd_pending", exp_all.size(), 0);
    chk("rnd_srcs_idle", sv[0] | sv[1] | sv[2], 0);
    chk("rnd_drop_cnt", bus.o_DROP_CNT, exp_drop > 255 ? 255 : exp_drop);
    chk("rnd_no_timeout", tmo_seen, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
